// File: rtl/otter_wb_arbiter.sv
// Two-port writeback arbiter for otter_rfile with starvation protection for the
// long-latency port and a scoreboard of outstanding port-B destinations.
module otter_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_valid,
    input  logic [4:0]  a_addr,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [4:0]  b_addr,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_addr,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_pend1,
    output logic        q_pend2,
    output logic        w_en,
    output logic [4:0]  w_addr,
    output logic [31:0] w_data
);

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        w_en_q, w_en_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic        w_from_b_q, w_from_b_d;
    logic [31:0] pending_q, pending_d;

    logic        force_b_s;
    logic        a_xfer_s;
    logic        b_xfer_s;

    // Arbitration: A has priority unless B has waited the full starvation limit.
    always_comb begin
        force_b_s = (starve_cnt_q == LIMIT_C);
        a_ready   = !force_b_s;
        b_ready   = force_b_s || !a_valid;
        a_xfer_s  = a_valid && a_ready;
        b_xfer_s  = b_valid && b_ready;
    end

    // Starvation counter next state; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!b_valid || b_xfer_s) begin
            starve_cnt_d = 4'd0;
        end else if (starve_cnt_q < LIMIT_C) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Write port next state; x0 transfers are accepted but dropped, leaving addr/data held.
    always_comb begin
        w_en_d     = 1'b0;
        w_addr_d   = w_addr_q;
        w_data_d   = w_data_q;
        w_from_b_d = 1'b0;
        if (a_xfer_s) begin
            if (a_addr != 5'd0) begin
                w_en_d   = 1'b1;
                w_addr_d = a_addr;
                w_data_d = a_data;
            end else begin
                w_en_d = 1'b0;
            end
        end else if (b_xfer_s) begin
            if (b_addr != 5'd0) begin
                w_en_d     = 1'b1;
                w_addr_d   = b_addr;
                w_data_d   = b_data;
                w_from_b_d = 1'b1;
            end else begin
                w_en_d = 1'b0;
            end
        end else begin
            w_en_d = 1'b0;
        end
    end

    // Scoreboard next state; the set is applied after the clear so a new allocation wins.
    always_comb begin
        pending_d = pending_q;
        if (w_en_q && w_from_b_q) begin
            pending_d[w_addr_q] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (alloc_valid && (alloc_addr != 5'd0)) begin
            pending_d[alloc_addr] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
            w_en_q       <= 1'b0;
            w_addr_q     <= 5'd0;
            w_data_q     <= 32'd0;
            w_from_b_q   <= 1'b0;
            pending_q    <= 32'd0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            w_en_q       <= w_en_d;
            w_addr_q     <= w_addr_d;
            w_data_q     <= w_data_d;
            w_from_b_q   <= w_from_b_d;
            pending_q    <= pending_d;
        end
    end

    assign q_pend1 = pending_q[q_addr1];
    assign q_pend2 = pending_q[q_addr2];
    assign w_en    = w_en_q;
    assign w_addr  = w_addr_q;
    assign w_data  = w_data_q;

endmodule

// File: tb/tb_otter_wb_arbiter.sv
// Self-checking bench for otter_wb_arbiter: directed scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_otter_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, alloc_valid;
    logic [4:0]  a_addr, b_addr, alloc_addr, q_addr1, q_addr2;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, q_pend1, q_pend2, w_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_wait;
    bit          m_pend [32];
    bit          m_en;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_from_b;
    bit          last_ax, last_bx;

    always #5 clk = ~clk;

    otter_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .alloc_valid(alloc_valid), .alloc_addr(alloc_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_pend1(q_pend1), .q_pend2(q_pend2),
        .w_en(w_en), .w_addr(w_addr), .w_data(w_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wait   = 0;
        m_en     = 1'b0;
        m_addr   = 5'd0;
        m_data   = 32'd0;
        m_from_b = 1'b0;
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    endtask

    task automatic idle_inputs();
        rst         = 1'b0;
        a_valid     = 1'b0; a_addr = 5'd0; a_data = 32'd0;
        b_valid     = 1'b0; b_addr = 5'd0; b_data = 32'd0;
        alloc_valid = 1'b0; alloc_addr = 5'd0;
        q_addr1     = 5'd0; q_addr2 = 5'd0;
    endtask

    // Called at a negedge with inputs driven; checks, advances one clock, ends at next negedge.
    task automatic step();
        bit fb, ar, br, ax, bx, exp_q1, exp_q2;
        #1;
        fb     = (m_wait == LIMIT);
        ar     = !fb;
        br     = fb || !a_valid;
        exp_q1 = (q_addr1 != 5'd0) && m_pend[q_addr1];
        exp_q2 = (q_addr2 != 5'd0) && m_pend[q_addr2];
        check_val("a_ready", {31'd0, a_ready}, {31'd0, ar});
        check_val("b_ready", {31'd0, b_ready}, {31'd0, br});
        check_val("q_pend1", {31'd0, q_pend1}, {31'd0, exp_q1});
        check_val("q_pend2", {31'd0, q_pend2}, {31'd0, exp_q2});
        check_val("w_en",    {31'd0, w_en},    {31'd0, m_en});
        check_val("w_addr",  {27'd0, w_addr},  {27'd0, m_addr});
        check_val("w_data",  w_data,           m_data);
        ax = a_valid && ar;
        bx = b_valid && br;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (m_en && m_from_b) m_pend[m_addr] = 1'b0;
            if (alloc_valid && alloc_addr != 5'd0) m_pend[alloc_addr] = 1'b1;
            m_wait = (b_valid && !bx) ? m_wait + 1 : 0;
            if (ax && a_addr != 5'd0) begin
                m_en = 1'b1; m_addr = a_addr; m_data = a_data; m_from_b = 1'b0;
            end else if (bx && b_addr != 5'd0) begin
                m_en = 1'b1; m_addr = b_addr; m_data = b_data; m_from_b = 1'b1;
            end else begin
                m_en = 1'b0; m_from_b = 1'b0;
            end
        end
        last_ax = ax;
        last_bx = bx;
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        last_ax = 1'b0;
        last_bx = 1'b0;
        idle_inputs();
        step();

        // single A write to x5
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h12345678;
        step();
        idle_inputs();
        check_val("a_only_w_en", {31'd0, w_en}, 32'd1);
        check_val("a_only_w_data", w_data, 32'h12345678);
        step();

        // contention: B starved for LIMIT cycles, then forced
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h0000_0011;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'h87654321;
        repeat (LIMIT) step();
        #1;
        check_val("starve_b_ready", {31'd0, b_ready}, 32'd1);
        check_val("starve_a_ready", {31'd0, a_ready}, 32'd0);
        step();
        b_valid = 1'b0;
        check_val("starve_w_addr", {27'd0, w_addr}, 32'd10);
        step();
        check_val("a_resumes_w_addr", {27'd0, w_addr}, 32'd1);
        idle_inputs();
        step();

        // scoreboard lifecycle on x15
        q_addr1 = 5'd15; alloc_valid = 1'b1; alloc_addr = 5'd15;
        step();
        alloc_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd15; b_data = 32'hCAFEBABE;
        step();
        b_valid = 1'b0;
        step();
        #1;
        check_val("sb_cleared", {31'd0, q_pend1}, 32'd0);
        idle_inputs();
        step();

        // x0 write dropped, x0 alloc ignored
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hDEADBEEF;
        step();
        idle_inputs();
        check_val("x0_w_en", {31'd0, w_en}, 32'd0);
        alloc_valid = 1'b1; alloc_addr = 5'd0;
        step();
        alloc_valid = 1'b0;
        step();

        // set/clear collision on x20
        alloc_valid = 1'b1; alloc_addr = 5'd20;
        step();
        alloc_valid = 1'b0;
        b_valid = 1'b1; b_addr = 5'd20; b_data = 32'h0000_2020;
        step();
        b_valid = 1'b0; alloc_valid = 1'b1; alloc_addr = 5'd20;
        step();
        idle_inputs();
        q_addr1 = 5'd20;
        #1;
        check_val("collision_set_wins", {31'd0, q_pend1}, 32'd1);
        step();

        // reset in the middle of activity
        alloc_valid = 1'b1; alloc_addr = 5'd3;
        step();
        alloc_addr = 5'd7;
        step();
        alloc_valid = 1'b0;
        a_valid = 1'b1; a_addr = 5'd9; a_data = 32'h0000_0099;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h0000_0044;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        q_addr1 = 5'd3; q_addr2 = 5'd7;
        check_val("rst_w_en", {31'd0, w_en}, 32'd0);
        step();
        idle_inputs();
        step();

        // randomized traffic honouring the hold-until-transfer rule
        for (int c = 0; c < 3000; c++) begin
            if (!(a_valid && !last_ax)) begin
                a_valid = 1'($urandom_range(0, 1));
                a_addr  = 5'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!(b_valid && !last_bx)) begin
                b_valid = 1'($urandom_range(0, 1));
                b_addr  = 5'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            alloc_valid = ($urandom_range(0, 3) == 0);
            alloc_addr  = 5'($urandom_range(0, 7));
            q_addr1     = 5'($urandom_range(0, 7));
            q_addr2     = 5'($urandom_range(0, 7));
            rst         = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/otter_wb_arbiter.md
OTTER_WB_ARBITER -- requirements
Module: otter_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3: max consecutive cycles port B may wait with b_valid high before it is forced a grant; legal range 1..15.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock; same clock as otter_rfile.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 a_valid  input  1  port A (pipeline writeback) write request.
REQ-006 a_addr  input  5  port A destination register.
REQ-007 a_data  input  32  port A write data.
REQ-008 a_ready  output  1  port A request accepted this cycle.
REQ-009 b_valid  input  1  port B (long-latency unit) write request.
REQ-010 b_addr  input  5  port B destination register.
REQ-011 b_data  input  32  port B write data.
REQ-012 b_ready  output  1  port B request accepted this cycle.
REQ-013 alloc_valid  input  1  issue stage reserves a port-B destination.
REQ-014 alloc_addr  input  5  register being reserved.
REQ-015 q_addr1, q_addr2  input  5 each  scoreboard query addresses (rs1/rs2).
REQ-016 q_pend1, q_pend2  output  1 each  queried register has an outstanding port-B write.
REQ-017 w_en, w_addr, w_data  output  1/5/32  registered drive to otter_rfile write port.

Function
REQ-018 Handshake: transfer on a port SHALL occur in any cycle where valid and ready are both high; valid/addr/data SHALL be held stable by the requester until transfer.
REQ-019 force_b SHALL be high when the starvation counter equals STARVE_LIMIT.
REQ-020 a_ready SHALL equal !force_b; b_ready SHALL equal force_b || !a_valid (combinational; at most one transfer per cycle).
REQ-021 Starvation counter (4 bits) SHALL increment each cycle with b_valid && !b_ready, SHALL clear on a B transfer or when b_valid is low, and SHALL never exceed STARVE_LIMIT.
REQ-022 Latency: a transfer in cycle N SHALL present w_en=1, w_addr, w_data in cycle N+1; otter_rfile captures at the end of N+1.
REQ-023 Transfers with addr=0 SHALL be accepted (ready behaves normally) but SHALL produce w_en=0 in N+1.
REQ-024 Cycles with no transfer SHALL produce w_en=0 in the next cycle; w_addr/w_data SHALL hold their previous values.
REQ-025 Scoreboard: 32-bit pending mask; bit 0 SHALL be constant 0.
REQ-026 alloc_valid with alloc_addr!=0 SHALL set pending[alloc_addr] at the clock edge.
REQ-027 pending[w_addr] SHALL clear at the edge ending a cycle in which w_en=1 and the write originated from port B; port-A writes SHALL NOT touch the mask.
REQ-028 Simultaneous set and clear of the same bit: set SHALL win.
REQ-029 q_pend1 = pending[q_addr1], q_pend2 = pending[q_addr2], combinational; q_addr=0 SHALL return 0.
REQ-030 A transfer on either port to a register also allocated that cycle SHALL NOT be treated specially beyond REQ-027/028.

Reset
REQ-031 rst high at a clock edge SHALL force: w_en=0, w_addr=0, w_data=0, starvation counter=0, pending mask=0.
REQ-032 Reset SHALL take priority over any transfer or alloc in the same cycle; a transfer accepted in the reset cycle SHALL be discarded (no w_en in the following cycle).
REQ-033 During and after reset, a_ready=1 and b_ready=!a_valid until the counter advances.

Verification
REQ-034 A only: a_valid=1, a_addr=5, a_data=0x12345678 one cycle -> a_ready=1, next cycle w_en=1, w_addr=5, w_data=0x12345678; rfile reads 0x12345678 on x5 afterward.
REQ-035 Contention, STARVE_LIMIT=3: a_valid held high, b_valid=1 b_addr=10 b_data=0x87654321 -> b_ready low 3 cycles, high 4th cycle with a_ready=0; w_en carries addr 10 in 5th cycle; A resumes next.
REQ-036 Scoreboard: alloc 15 -> q_addr1=15 gives q_pend1=1; B write 15=0xCAFEBABE -> q_pend1=1 through the w_en cycle, 0 the cycle after, rfile x15=0xCAFEBABE.
REQ-037 x0: A transfer addr 0 data 0xDEADBEEF -> a_ready=1, w_en stays 0, rfile x0 reads 0; alloc addr 0 -> q_pend for 0 stays 0.
REQ-038 Set/clear collision: B write to 20 on w_en in same cycle as alloc 20 -> pending[20]=1 afterward.
REQ-039 Reset mid-operation: alloc 3 and 7, B waiting 2 cycles, assert rst one cycle with a transfer -> w_en=0 next cycle, q_pend for 3 and 7 =0, counter restarts from 0.
